serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 94 +++++++++
 tb/tb_serial_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per cycle, LSB first, with a
// registered carry and a three-state control FSM (IDLE/RUN/FIN).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last, accept;
  logic             ha1_s, ha1_c, ha2_s, ha2_c, sbit, cnext;

  // Full adder as two half adders plus an OR on the carries
  always_comb begin
    ha1_s = a_sh[0] ^ b_sh[0];
    ha1_c = a_sh[0] & b_sh[0];
    ha2_s = ha1_s ^ carry;
    ha2_c = ha1_s & carry;
    sbit  = ha2_s;
    cnext = ha1_c | ha2_c;
  end

  // New sum bit enters at the MSB; after WIDTH steps the first bit lands at bit 0
  assign sum_nx = {sbit, {(WIDTH-1){1'b0}}} | (sum_sh >> 1);

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = START && (state != RUN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START) state_nx = RUN;
      RUN:     if (last) state_nx = FIN;
      FIN:     state_nx = START ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      S      <= '0;
      Cout   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh   <= A;
        b_sh   <= B;
        carry  <= Cin;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        carry  <= cnext;
        sum_sh <= sum_nx;
        cnt    <= cnt + 1'b1;
        if (last) begin
          S    <= sum_nx;
          Cout <= cnext;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 scenarios with hand-computed
// results plus an exhaustive operand sweep on a WIDTH=2 instance.
module tb_serial_adder;

  logic       CLK = 1'b0;
  logic       RST, START, Cin;
  logic [7:0] A, B, S;
  logic       Cout, BUSY, DONE;

  logic       START2, Cin2;
  logic [1:0] A2, B2, S2;
  logic       Cout2, BUSY2, DONE2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  serial_adder #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .Cin(Cin),
    .S(S), .Cout(Cout), .BUSY(BUSY), .DONE(DONE)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .START(START2), .A(A2), .B(B2), .Cin(Cin2),
    .S(S2), .Cout(Cout2), .BUSY(BUSY2), .DONE(DONE2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Waits for DONE on the 8-bit instance; returns cycles waited and any BUSY/DONE overlap
  task automatic wait_done(input int start_cyc, output int cyc, output logic overlap);
    cyc = start_cyc;
    overlap = 1'b0;
    while (!DONE && cyc < 20) begin
      tick;
      cyc++;
      if (BUSY && DONE) overlap = 1'b1;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic [7:0] exp_s, input logic exp_c);
    int cyc;
    logic ov;
    logic [8:0] sb;
    A = a; B = b; Cin = cin; START = 1'b1;
    tick;
    START = 1'b0;
    chk({tag, " busy_after_accept"}, BUSY, 1);
    chk({tag, " done_after_accept"}, DONE, 0);
    wait_done(0, cyc, ov);
    chk({tag, " latency"}, cyc, 8);
    chk({tag, " busy_done_overlap"}, ov, 0);
    chk({tag, " busy_in_fin"}, BUSY, 0);
    chk({tag, " S"}, S, exp_s);
    chk({tag, " Cout"}, Cout, exp_c);
    sb = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    chk({tag, " scoreboard"}, {Cout, S}, sb);
    tick;
    chk({tag, " done_one_cycle"}, DONE, 0);
    chk({tag, " S_hold"}, S, exp_s);
  endtask

  initial begin
    int   cyc, extra;
    logic ov;

    RST = 1'b1; START = 1'b0; A = '0; B = '0; Cin = 1'b0;
    START2 = 1'b0; A2 = '0; B2 = '0; Cin2 = 1'b0;
    tick;
    tick;
    chk("reset S", S, 0);
    chk("reset Cout", Cout, 0);
    chk("reset BUSY", BUSY, 0);
    chk("reset DONE", DONE, 0);
    RST = 1'b0;

    // First START right as reset drops
    op8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    op8("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("max", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    op8("mixed", 8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0);

    // START held through RUN with operands changing underneath
    A = 8'h3C; B = 8'h5A; Cin = 1'b0; START = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      A = 8'hFF; B = 8'hFF; Cin = 1'b1;
      tick;
    end
    START = 1'b0;
    chk("ignored busy_mid", BUSY, 1);
    wait_done(5, cyc, ov);
    chk("ignored latency", cyc, 8);
    chk("ignored S", S, 8'h96);
    chk("ignored Cout", Cout, 0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (DONE) extra++;
    end
    chk("ignored single_done", extra, 0);

    // Reset four cycles into RUN
    A = 8'h12; B = 8'h34; Cin = 1'b0; START = 1'b1;
    tick;
    START = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("rstmid BUSY", BUSY, 0);
    chk("rstmid DONE", DONE, 0);
    chk("rstmid S", S, 0);
    chk("rstmid Cout", Cout, 0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (DONE || BUSY) extra++;
    end
    chk("rstmid no_activity", extra, 0);
    op8("after_rst", 8'h0F, 8'hF1, 1'b1, 8'h01, 1'b1);

    // Back-to-back accept during FIN
    A = 8'h12; B = 8'h34; Cin = 1'b1; START = 1'b1;
    tick;
    START = 1'b0;
    wait_done(0, cyc, ov);
    chk("b2b first S", S, 8'h47);
    A = 8'h80; B = 8'h80; Cin = 1'b0; START = 1'b1;
    tick;
    START = 1'b0;
    chk("b2b busy", BUSY, 1);
    tick;
    tick;
    chk("b2b S_hold_run", S, 8'h47);
    wait_done(3, cyc, ov);
    chk("b2b spacing", cyc, 9);
    chk("b2b S", S, 8'h00);
    chk("b2b Cout", Cout, 1);
    tick;

    // Exhaustive WIDTH=2 sweep
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          A2 = 2'(a); B2 = 2'(b); Cin2 = 1'(c); START2 = 1'b1;
          tick;
          START2 = 1'b0;
          cyc = 0;
          while (!DONE2 && cyc < 10) begin
            tick;
            cyc++;
          end
          chk($sformatf("w2 latency %0d+%0d+%0d", a, b, c), cyc, 2);
          chk($sformatf("w2 sum %0d+%0d+%0d", a, b, c), {Cout2, S2}, a + b + c);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
